// File: rtl/vsfx_avgh_seq_pkg.sv
// Shared VSFX constants: slice/halfword widths, sequencer state encoding, average op encoding.
// No logic; imported by the interface, lane and sequencer.
package vsfx_pkg;
    localparam int VSFX_SLICE_W = 32;
    localparam int VSFX_HW_W    = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } vsfx_state_e;

    localparam logic VSFX_AVG_S = 1'b0;
    localparam logic VSFX_AVG_U = 1'b1;
endpackage

// File: rtl/vsfx_avgh_seq_if.sv
// Op/result handshake bundle between upstream issue, the avgh sequencer and VSFX writeback.
// Valid/ready on both sides; master drives ops and result-ready, slave is the sequencer.
interface vsfx_avgh_seq_if #(
    parameter int NSLICE = 4,
    parameter int TAG_W  = 6
);
    import vsfx_pkg::*;
    localparam int VW = VSFX_SLICE_W * NSLICE;

    logic             in_valid;
    logic             in_ready;
    logic             in_op;
    logic [TAG_W-1:0] in_tag;
    logic [VW-1:0]    in_vra;
    logic [VW-1:0]    in_vrb;
    logic             out_valid;
    logic             out_ready;
    logic [TAG_W-1:0] out_tag;
    logic [VW-1:0]    out_vrt;

    modport master (
        output in_valid, in_op, in_tag, in_vra, in_vrb, out_ready,
        input  in_ready, out_valid, out_tag, out_vrt
    );

    modport slave (
        input  in_valid, in_op, in_tag, in_vra, in_vrb, out_ready,
        output in_ready, out_valid, out_tag, out_vrt
    );
endinterface

// File: rtl/vsfx_avgh_seq_lane.sv
// 32-bit halfword-average lane: two 17-bit rounding averagers, signed or unsigned per op.
// Purely combinational, zero latency, no flow control.
module vsfx_avgh_lane
    import vsfx_pkg::*;
(
    input  logic [VSFX_SLICE_W-1:0] a,
    input  logic [VSFX_SLICE_W-1:0] b,
    input  logic                    op,
    output logic [VSFX_SLICE_W-1:0] r
);
    localparam int NHW = VSFX_SLICE_W / VSFX_HW_W;
    localparam logic [VSFX_HW_W:0] ONE = {{VSFX_HW_W{1'b0}}, 1'b1};

    for (genvar h = 0; h < NHW; h++) begin : g_hw
        logic [VSFX_HW_W-1:0] w_ah;
        logic [VSFX_HW_W-1:0] w_bh;
        logic [VSFX_HW_W:0]   w_ax;
        logic [VSFX_HW_W:0]   w_bx;
        logic [VSFX_HW_W:0]   w_sum;

        assign w_ah = a[h*VSFX_HW_W +: VSFX_HW_W];
        assign w_bh = b[h*VSFX_HW_W +: VSFX_HW_W];
        // One extra bit holds the full sum; bit 16 then doubles as the sign for the arithmetic shift.
        assign w_ax = (op == VSFX_AVG_U) ? {1'b0, w_ah} : {w_ah[VSFX_HW_W-1], w_ah};
        assign w_bx = (op == VSFX_AVG_U) ? {1'b0, w_bh} : {w_bh[VSFX_HW_W-1], w_bh};
        assign w_sum = w_ax + w_bx + ONE;
        assign r[h*VSFX_HW_W +: VSFX_HW_W] = w_sum[VSFX_HW_W:1];
    end
endmodule

// File: rtl/vsfx_avgh_seq.sv
// Sequences one 32*NSLICE-bit avgh op through a single 32-bit lane, one slice per cycle.
// Result valid NSLICE edges after accept; holds in DONE under backpressure, accepts next op on release.
module vsfx_avgh_seq
    import vsfx_pkg::*;
#(
    parameter int NSLICE = 4,
    parameter int TAG_W  = 6
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    vsfx_avgh_seq_if.slave bus
);
    localparam int CNT_W = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NSLICE - 1);

    vsfx_state_e r_state;
    vsfx_state_e w_state_nxt;
    logic [CNT_W-1:0]                     r_cnt;
    logic [NSLICE-1:0][VSFX_SLICE_W-1:0] r_vra;
    logic [NSLICE-1:0][VSFX_SLICE_W-1:0] r_vrb;
    logic [NSLICE-1:0][VSFX_SLICE_W-1:0] r_vrt;
    logic                                 r_op;
    logic [TAG_W-1:0]                     r_tag;
    logic                                 w_in_ready;
    logic                                 w_accept;
    logic [VSFX_SLICE_W-1:0]              w_slice_r;

    // flush masks in_ready so it wins over any handshake in the same cycle
    always_comb begin
        w_in_ready  = ~flush & ((r_state == IDLE) | ((r_state == DONE) & bus.out_ready));
        w_accept    = w_in_ready & bus.in_valid;
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_accept) w_state_nxt = RUN;
                RUN:     if (r_cnt == LAST) w_state_nxt = DONE;
                DONE:    if (bus.out_ready) w_state_nxt = w_accept ? RUN : IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_vra <= '0;
            r_vrb <= '0;
            r_vrt <= '0;
            r_op  <= 1'b0;
            r_tag <= '0;
        end else begin
            if (w_accept) begin
                r_vra <= bus.in_vra;
                r_vrb <= bus.in_vrb;
                r_op  <= bus.in_op;
                r_tag <= bus.in_tag;
            end
            if (flush || w_accept) begin
                r_cnt <= '0;
            end else if (r_state == RUN) begin
                r_vrt[r_cnt] <= w_slice_r;
                r_cnt        <= r_cnt + CNT_W'(1);
            end
        end
    end

    vsfx_avgh_lane u_lane (
        .a  (r_vra[r_cnt]),
        .b  (r_vrb[r_cnt]),
        .op (r_op),
        .r  (w_slice_r)
    );

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_state == DONE);
    assign bus.out_tag   = r_tag;
    assign bus.out_vrt   = r_vrt;
endmodule

// File: tb/tb_vsfx_avgh_seq.sv
// Directed and random bench for vsfx_avgh_seq against a halfword-average reference model.
module tb_vsfx_avgh_seq;
    localparam int NSLICE = 4;
    localparam int TAG_W  = 6;
    localparam int VW     = 32 * NSLICE;

    logic clk;
    logic rst_n;
    logic flush;
    int   checks;
    int   errors;

    vsfx_avgh_seq_if #(.NSLICE(NSLICE), .TAG_W(TAG_W)) bus ();

    vsfx_avgh_seq #(.NSLICE(NSLICE), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [VW-1:0] ref_avg(input logic op, input logic [VW-1:0] a,
                                              input logic [VW-1:0] b);
        logic [VW-1:0] r;
        logic [15:0]   ha;
        logic [15:0]   hb;
        int x;
        int y;
        int s;
        r = '0;
        for (int h = 0; h < VW / 16; h++) begin
            ha = a[16*h +: 16];
            hb = b[16*h +: 16];
            if (op) begin
                x = int'({16'b0, ha});
                y = int'({16'b0, hb});
            end else begin
                x = int'($signed(ha));
                y = int'($signed(hb));
            end
            s = (x + y + 1) >>> 1;
            r[16*h +: 16] = s[15:0];
        end
        return r;
    endfunction

    function automatic logic [VW-1:0] rnd_vec();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic op, input logic [TAG_W-1:0] tag,
                        input logic [VW-1:0] a, input logic [VW-1:0] b);
        bus.in_op  = op;
        bus.in_tag = tag;
        bus.in_vra = a;
        bus.in_vrb = b;
    endtask

    task automatic scramble_inputs();
        bus.in_op  = 1'($urandom);
        bus.in_tag = TAG_W'($urandom);
        bus.in_vra = rnd_vec();
        bus.in_vrb = rnd_vec();
    endtask

    task automatic wait_vld(input string tag);
        int n;
        n = 0;
        while (!bus.out_valid && n < 30) begin
            tick();
            n++;
        end
        chk(tag, VW'(bus.out_valid), VW'(1));
    endtask

    // Accept one op with out_ready=1; returns the result, its tag and edges from accept to out_valid.
    task automatic do_op(input logic op, input logic [TAG_W-1:0] tag,
                         input logic [VW-1:0] a, input logic [VW-1:0] b,
                         output logic [VW-1:0] vrt, output logic [TAG_W-1:0] otag,
                         output int lat);
        int w;
        load(op, tag, a, b);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        w = 0;
        while (!bus.in_ready && w < 30) begin
            tick();
            w++;
        end
        tick();
        bus.in_valid = 1'b0;
        scramble_inputs();
        lat = 0;
        while (!bus.out_valid && lat < 30) begin
            tick();
            lat++;
        end
        vrt  = bus.out_vrt;
        otag = bus.out_tag;
        tick();
    endtask

    logic [15:0]       sa [5] = '{16'hFFFF, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h7FFF};
    logic [15:0]       sb [5] = '{16'h0001, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h8000};
    logic [15:0]       se [5] = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0000};
    logic [VW-1:0]     va, vb, vexp, vrt;
    logic [TAG_W-1:0]  otag;
    logic              rop;
    logic [TAG_W-1:0]  rtag;
    int                lat;
    logic [VW-1:0]     ba [3];
    logic [VW-1:0]     bb [3];
    logic              bo [3];
    logic [TAG_W-1:0]  bt [3];

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        flush = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        load(1'b0, '0, '0, '0);

        // reset state
        #1;
        chk("rst_out_valid", VW'(bus.out_valid), VW'(0));
        chk("rst_out_vrt", bus.out_vrt, '0);
        chk("rst_out_tag", VW'(bus.out_tag), VW'(0));
        tick();
        tick();
        #2 rst_n = 1'b1;
        tick();
        chk("rst_in_ready", VW'(bus.in_ready), VW'(1));

        // signed rounding cases in slice 0
        for (int i = 0; i < 5; i++) begin
            va = rnd_vec();
            vb = rnd_vec();
            va[31:0] = {sa[i], sa[i]};
            vb[31:0] = {sb[i], sb[i]};
            do_op(1'b0, TAG_W'(i), va, vb, vrt, otag, lat);
            chk($sformatf("signed_s0_%0d", i), VW'(vrt[31:0]), VW'({se[i], se[i]}));
            chk($sformatf("signed_full_%0d", i), vrt, ref_avg(1'b0, va, vb));
        end

        // unsigned cases with distinct slice 3 for ordering
        va   = {32'h1234_0010, 32'h0001_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vb   = {32'h5678_0020, 32'h0002_0002, 32'h0000_0000, 32'hFFFF_FFFF};
        vexp = {32'h3456_0018, 32'h0002_0002, 32'h8000_8000, 32'hFFFF_FFFF};
        do_op(1'b1, 6'h2A, va, vb, vrt, otag, lat);
        chk("unsigned_vec", vrt, vexp);
        chk("unsigned_tag", VW'(otag), VW'(6'h2A));

        // latency
        va = rnd_vec();
        vb = rnd_vec();
        do_op(1'b0, 6'h05, va, vb, vrt, otag, lat);
        chk("latency", VW'(lat), VW'(NSLICE));
        chk("latency_data", vrt, ref_avg(1'b0, va, vb));

        // back-to-back ops with out_ready held high
        for (int i = 0; i < 3; i++) begin
            ba[i] = rnd_vec();
            bb[i] = rnd_vec();
            bo[i] = 1'($urandom);
            bt[i] = TAG_W'(6'h11 * (i + 1));
        end
        begin
            int k;
            int t;
            int acc_t;
            load(bo[0], bt[0], ba[0], bb[0]);
            bus.in_valid  = 1'b1;
            bus.out_ready = 1'b1;
            tick();
            load(bo[1], bt[1], ba[1], bb[1]);
            k = 0;
            t = 0;
            acc_t = 0;
            while (k < 3 && t < 60) begin
                if (bus.out_valid) begin
                    chk($sformatf("b2b_lat_%0d", k), VW'(t - acc_t), VW'(NSLICE));
                    chk($sformatf("b2b_in_ready_%0d", k), VW'(bus.in_ready), VW'(1));
                    chk($sformatf("b2b_tag_%0d", k), VW'(bus.out_tag), VW'(bt[k]));
                    chk($sformatf("b2b_data_%0d", k), bus.out_vrt, ref_avg(bo[k], ba[k], bb[k]));
                    acc_t = t + 1;
                    tick();
                    t++;
                    k++;
                    if (k + 1 < 3) load(bo[k+1], bt[k+1], ba[k+1], bb[k+1]);
                    else bus.in_valid = 1'b0;
                end else begin
                    tick();
                    t++;
                end
            end
            chk("b2b_all_done", VW'(k), VW'(3));
            bus.in_valid = 1'b0;
        end

        // backpressure for 10 cycles, then release with a new op waiting
        va = rnd_vec();
        vb = rnd_vec();
        load(1'b1, 6'h3C, va, vb);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        scramble_inputs();
        wait_vld("bp_valid");
        vexp = ref_avg(1'b1, va, vb);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("bp_vrt_%0d", i), bus.out_vrt, vexp);
            chk($sformatf("bp_tag_%0d", i), VW'(bus.out_tag), VW'(6'h3C));
            chk($sformatf("bp_in_ready_%0d", i), VW'(bus.in_ready), VW'(0));
            chk($sformatf("bp_out_valid_%0d", i), VW'(bus.out_valid), VW'(1));
            tick();
        end
        va = rnd_vec();
        vb = rnd_vec();
        load(1'b0, 6'h07, va, vb);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", VW'(bus.in_ready), VW'(1));
        tick();
        bus.in_valid = 1'b0;
        scramble_inputs();
        chk("bp_release_valid_low", VW'(bus.out_valid), VW'(0));
        wait_vld("bp_next_valid");
        chk("bp_next_data", bus.out_vrt, ref_avg(1'b0, va, vb));
        chk("bp_next_tag", VW'(bus.out_tag), VW'(6'h07));
        tick();

        // flush in the second RUN cycle
        load(1'b0, 6'h19, rnd_vec(), rnd_vec());
        bus.in_valid = 1'b1;
        tick();
        tick();
        flush = 1'b1;
        #1;
        chk("flush_in_ready", VW'(bus.in_ready), VW'(0));
        tick();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("flush_in_ready_after", VW'(bus.in_ready), VW'(1));
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("flush_no_valid_%0d", i), VW'(bus.out_valid), VW'(0));
            tick();
        end
        va = rnd_vec();
        vb = rnd_vec();
        do_op(1'b1, 6'h1A, va, vb, vrt, otag, lat);
        chk("flush_next_data", vrt, ref_avg(1'b1, va, vb));
        chk("flush_next_tag", VW'(otag), VW'(6'h1A));

        // async reset mid-RUN
        bus.out_ready = 1'b0;
        load(1'b0, 6'h2B, rnd_vec(), rnd_vec());
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        #1 rst_n = 1'b0;
        #1;
        chk("rst_run_valid", VW'(bus.out_valid), VW'(0));
        chk("rst_run_vrt", bus.out_vrt, '0);
        chk("rst_run_tag", VW'(bus.out_tag), VW'(0));
        #1 rst_n = 1'b1;
        tick();
        chk("rst_run_idle", VW'(bus.in_ready), VW'(1));

        // async reset in DONE
        load(1'b1, 6'h3F, rnd_vec(), rnd_vec());
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        wait_vld("rst_done_reach");
        #1 rst_n = 1'b0;
        #1;
        chk("rst_done_valid", VW'(bus.out_valid), VW'(0));
        #1 rst_n = 1'b1;
        tick();
        chk("rst_done_valid_after", VW'(bus.out_valid), VW'(0));
        chk("rst_done_vrt", bus.out_vrt, '0);
        chk("rst_done_tag", VW'(bus.out_tag), VW'(0));
        chk("rst_done_idle", VW'(bus.in_ready), VW'(1));

        // random ops with random backpressure
        for (int n = 0; n < 10000; n++) begin
            bit got;
            int c;
            rop  = 1'($urandom);
            rtag = TAG_W'($urandom);
            va   = rnd_vec();
            vb   = rnd_vec();
            load(rop, rtag, va, vb);
            bus.in_valid  = 1'b1;
            bus.out_ready = 1'($urandom);
            #1;
            c = 0;
            while (!bus.in_ready && c < 30) begin
                tick();
                c++;
            end
            tick();
            bus.in_valid = 1'b0;
            scramble_inputs();
            vexp = ref_avg(rop, va, vb);
            got = 1'b0;
            c = 0;
            while (!got && c < 200) begin
                bus.out_ready = ($urandom_range(0, 3) != 0);
                if (bus.out_valid && bus.out_ready) begin
                    chk("rnd_data", bus.out_vrt, vexp);
                    chk("rnd_tag", VW'(bus.out_tag), VW'(rtag));
                    got = 1'b1;
                end
                tick();
                c++;
            end
            if (!got) chk("rnd_timeout", VW'(got), VW'(1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
